// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Request/response bundle between the core's load/store port
//                (master) and the data-memory responder (slave).
//  Signals     : req_valid/req_ready    request handshake
//                req_we, req_funct3     store flag and RV32I width code
//                req_addr, req_wdata    byte address and right-aligned data
//                rsp_valid/rsp_ready    response handshake
//                rsp_rdata, rsp_err     extended load data and fault flag
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder for an RV32I core.
//                Accepts one load/store, waits LATENCY cycles, performs the
//                byte/halfword/word access on an internal RAM and returns a
//                registered, extended response held until accepted.
//  Parameters  : DEPTH   RAM size in 32-bit words (power of two, >= 4)
//                LATENCY wait states between acceptance and response (0..15)
//  Ports       : clk     rising-edge clock
//                reset   asynchronous active-high reset (RAM not cleared)
//                bus     dmem_responder_if slave modport
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dmem_responder_if.slave    bus
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] C_LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    logic        w_req_ready;
    logic        w_rsp_valid;
    logic        w_accept;
    logic        w_access;

    logic        w_we;
    logic [2:0]  w_f3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [AW-1:0] w_idx;
    logic [1:0]  w_lane;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_misalign;
    logic        w_err;

    // ------------------------------------------------------------------
    // FSM: state register and next-state / handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid)
                    w_next = (C_LAT == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) w_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    // Zero-latency builds access RAM on the acceptance edge itself.
    assign w_access = (w_accept && (C_LAT == 4'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // ------------------------------------------------------------------
    // Access operands: the live bus in IDLE (zero-latency path), the
    // latched request otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we    = bus.req_we;
            w_f3    = bus.req_funct3;
            w_addr  = bus.req_addr;
            w_wdata = bus.req_wdata;
        end else begin
            w_we    = r_we;
            w_f3    = r_funct3;
            w_addr  = r_addr;
            w_wdata = r_wdata;
        end
    end

    assign w_idx  = w_addr[AW+1:2];
    assign w_lane = w_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

    // Fault detection: alignment, width code legality, and range
    always_comb begin
        w_misalign = 1'b1;
        case (w_f3)
            3'b000: w_misalign = 1'b0;
            3'b001: w_misalign = w_addr[0];
            3'b010: w_misalign = |w_addr[1:0];
            3'b100: w_misalign = w_we;              // no unsigned stores
            3'b101: w_misalign = w_we | w_addr[0];
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_err = w_misalign | (|w_addr[31:AW+2]);

    always_comb begin
        w_load = 32'h0;
        case (w_f3)
            3'b000: w_load = {{24{w_byte[7]}}, w_byte};
            3'b001: w_load = {{16{w_half[15]}}, w_half};
            3'b010: w_load = w_word;
            3'b100: w_load = {24'h0, w_byte};
            3'b101: w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    // Read-modify-write merge so unselected lanes keep their old bytes
    always_comb begin
        w_merged = w_word;
        case (w_f3[1:0])
            2'b00:   w_merged[{w_lane, 3'b000} +: 8]     = w_wdata[7:0];
            2'b01:   w_merged[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
            default: w_merged = w_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter, registered response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_cnt    <= 4'd0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_cnt    <= C_LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'h0 : w_load;
            end
        end
    end

    // RAM has no reset; reset only blocks a write on the edge it covers.
    always_ff @(posedge clk) begin
        if (!reset && w_access && w_we && !w_err)
            r_mem[w_idx] <= w_merged;
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder. Two
//                instances: LATENCY=2 (sel=0) and LATENCY=0 (sel=1), driven
//                from one shared set of request variables.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic        sel     = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_we    = 1'b0;
    logic [2:0]  t_f3    = 3'b0;
    logic [31:0] t_addr  = 32'h0;
    logic [31:0] t_wdata = 32'h0;
    logic        t_rready = 1'b1;

    assign if0.req_valid  = t_valid & ~sel;
    assign if1.req_valid  = t_valid & sel;
    assign if0.req_we     = t_we;
    assign if1.req_we     = t_we;
    assign if0.req_funct3 = t_f3;
    assign if1.req_funct3 = t_f3;
    assign if0.req_addr   = t_addr;
    assign if1.req_addr   = t_addr;
    assign if0.req_wdata  = t_wdata;
    assign if1.req_wdata  = t_wdata;
    assign if0.rsp_ready  = t_rready;
    assign if1.rsp_ready  = t_rready;

    wire        m_ready = sel ? if1.req_ready : if0.req_ready;
    wire        m_valid = sel ? if1.rsp_valid : if0.rsp_valid;
    wire [31:0] m_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
    wire        m_err   = sel ? if1.rsp_err   : if0.rsp_err;

    int tests = 0;
    int fails = 0;

    int          lat;
    logic [31:0] rd;
    logic        e;

    // One transaction, called at a negedge; returns at a negedge after the
    // response handshake. lat = index of the edge at which rsp_valid is
    // first sampled high (acceptance edge = 0), -1 on timeout.
    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        t_valid = 1'b1; t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wdata;
        t_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // scramble request fields; they must be ignored after acceptance
        t_valid = 1'b0; t_we = ~we; t_f3 = 3'b010; t_addr = 32'hFFFF_FFFF; t_wdata = ~wdata;
        lat = -1; rd = 32'hX; e = 1'bX;
        for (int k = 1; k <= 40; k++) begin
            if (m_valid) begin
                lat = k; rd = m_rdata; e = m_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests++; if (m_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", m_ready); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", m_valid); end
        tests++; if (m_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b expected 0", m_err); end
        tests++; if (m_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata: got %h expected 0", m_rdata); end
    endtask

    task automatic test_word();
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        tests++; if (lat !== 3) begin fails++; $display("FAIL sw_latency: got %0d expected 3", lat); end
        tests++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sw_rsp: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
        tests++; if (m_valid !== 1'b0 || m_ready !== 1'b1) begin fails++; $display("FAIL sw_pulse: got valid=%b ready=%b expected 0/1", m_valid, m_ready); end
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (lat !== 3) begin fails++; $display("FAIL lw_latency: got %0d expected 3", lat); end
        tests++; if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rsp: got err=%b rdata=%h expected err=0 rdata=deadbeef", e, rd); end
    endtask

    task automatic test_subword();
        xact(1'b1, 3'b000, 32'h11, 32'h1234565A);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (rd !== 32'hDEAD5AEF) begin fails++; $display("FAIL sb_lw: got %h expected dead5aef", rd); end
        xact(1'b0, 3'b000, 32'h13, 32'h0);
        tests++; if (rd !== 32'hFFFFFFDE) begin fails++; $display("FAIL lb_neg: got %h expected ffffffde", rd); end
        xact(1'b0, 3'b100, 32'h13, 32'h0);
        tests++; if (rd !== 32'h000000DE) begin fails++; $display("FAIL lbu: got %h expected 000000de", rd); end
        xact(1'b0, 3'b001, 32'h12, 32'h0);
        tests++; if (rd !== 32'hFFFFDEAD) begin fails++; $display("FAIL lh_neg: got %h expected ffffdead", rd); end
        xact(1'b0, 3'b000, 32'h11, 32'h0);
        tests++; if (rd !== 32'h0000005A) begin fails++; $display("FAIL lb_pos: got %h expected 0000005a", rd); end
        xact(1'b1, 3'b001, 32'h12, 32'hABCD1234);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (rd !== 32'h12345AEF) begin fails++; $display("FAIL sh_lw: got %h expected 12345aef", rd); end
        xact(1'b0, 3'b101, 32'h10, 32'h0);
        tests++; if (rd !== 32'h00005AEF) begin fails++; $display("FAIL lhu: got %h expected 00005aef", rd); end
    endtask

    task automatic test_errors();
        xact(1'b0, 3'b010, 32'h12, 32'h0);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_misaligned: got err=%b rdata=%h expected err=1 rdata=0", e, rd); end
        xact(1'b1, 3'b001, 32'h13, 32'h0000FFFF);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL sh_misaligned: got err=%b expected 1", e); end
        xact(1'b1, 3'b100, 32'h10, 32'h00000000);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL store_unsigned: got err=%b expected 1", e); end
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        tests++; if (e !== 1'b0 || rd !== 32'h12345AEF) begin fails++; $display("FAIL err_no_write: got err=%b rdata=%h expected err=0 rdata=12345aef", e, rd); end
        xact(1'b0, 3'b010, 32'h100, 32'h0);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_range: got err=%b rdata=%h expected err=1 rdata=0", e, rd); end
        xact(1'b0, 3'b010, 32'h80000010, 32'h0);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL lw_range_high: got err=%b expected 1", e); end
        xact(1'b0, 3'b011, 32'h10, 32'h0);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL funct3_011: got err=%b rdata=%h expected err=1 rdata=0", e, rd); end
    endtask

    task automatic test_hold();
        logic seen;
        t_valid = 1'b1; t_we = 1'b0; t_f3 = 3'b010; t_addr = 32'h10; t_rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0; t_addr = 32'h0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL hold_timeout: got no rsp_valid expected rsp_valid"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b1 || m_ready !== 1'b0 || m_rdata !== 32'h12345AEF || m_err !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable: got valid=%b ready=%b rdata=%h err=%b expected 1/0/12345aef/0",
                         m_valid, m_ready, m_rdata, m_err);
            end
        end
        t_rready = 1'b1;
        @(negedge clk);
        tests++; if (m_valid !== 1'b0 || m_ready !== 1'b1) begin fails++; $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", m_valid, m_ready); end
    endtask

    task automatic test_reset_in_wait();
        xact(1'b1, 3'b010, 32'h20, 32'h0);
        t_valid = 1'b1; t_we = 1'b1; t_f3 = 3'b010; t_addr = 32'h20; t_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        tests++; if (m_ready !== 1'b0) begin fails++; $display("FAIL wait_ready: got %b expected 0", m_ready); end
        reset = 1'b1;
        #1;
        tests++; if (m_ready !== 1'b1 || m_valid !== 1'b0) begin fails++; $display("FAIL async_reset: got ready=%b valid=%b expected 1/0", m_ready, m_valid); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL after_reset_valid: got %b expected 0", m_valid); end
        xact(1'b0, 3'b010, 32'h20, 32'h0);
        tests++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL discarded_store: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
    endtask

    task automatic test_back_to_back_lat0();
        sel = 1'b1;
        xact(1'b1, 3'b010, 32'h8, 32'hCAFEF00D);
        tests++; if (lat !== 1) begin fails++; $display("FAIL lat0_sw_latency: got %0d expected 1", lat); end
        xact(1'b0, 3'b010, 32'h8, 32'h0);
        tests++; if (lat !== 1) begin fails++; $display("FAIL lat0_lw_latency: got %0d expected 1", lat); end
        tests++; if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin fails++; $display("FAIL lat0_lw_data: got err=%b rdata=%h expected err=0 rdata=cafef00d", e, rd); end
        xact(1'b0, 3'b100, 32'hB, 32'h0);
        tests++; if (rd !== 32'h000000CA) begin fails++; $display("FAIL lat0_lbu: got %h expected 000000ca", rd); end
        xact(1'b1, 3'b000, 32'h9, 32'hFFFFFF11);
        xact(1'b0, 3'b010, 32'h8, 32'h0);
        tests++; if (rd !== 32'hCAFE110D) begin fails++; $display("FAIL lat0_sb_lw: got %h expected cafe110d", rd); end
        sel = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_hold();
        test_reset_in_wait();
        test_back_to_back_lat0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
